// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

  localparam int unsigned LAT_DEFAULT = 2;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - per-word RAM latency counter with clear/enable
module lat_counter
  import mem_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  // The final latency cycle is the one in which ramload is valid.
  assign done_o = (cnt_q == CNT_W'(LAT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, dcache strictly over icache
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload
);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt;

  lat_counter #(
    .LAT (LAT)
  ) u_lat_counter (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .done_o (cnt_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Returning to IDLE after every word lets a waiting dcache re-win
  // arbitration, so block transfers are never split by icache fetches.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (dREN || dWEN) begin
          state_d = DACC;
        end else if (iREN) begin
          state_d = IACC;
        end
      end
      DACC: begin
        cnt_en   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end
      end
      IACC: begin
        cnt_en  = 1'b1;
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. Accepts word-granular read requests from the icache and read/write requests from the dcache control unit (dREN/dWEN/dwait handshake). Serialises them onto one fixed-latency RAM port and returns per-requester wait/data. The dcache has strict priority, so its back-to-back block transactions (write-back words, then fill words) are never interleaved with icache fetches.

## Interface
Parameters:
- LAT, 2: RAM access latency in cycles per word; legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  icache read request; held until iwait low.
- iaddr  in  AW  icache word address.
- iwait  out  1  low for exactly one cycle when the icache read completes.
- iload  out  DW  icache read data; valid only while iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins if asserted together with dREN.
- daddr  in  AW  dcache word address.
- dstore  in  DW  dcache write data.
- dwait  out  1  low for exactly one cycle when the dcache access completes.
- dload  out  DW  dcache read data; valid only while dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data, valid in the final latency cycle.

## Operation
- FSM states: IDLE, IACC, DACC. Shared latency counter cnt is 4 bits.
- IDLE:
  - dREN|dWEN → DACC, cnt←0.
  - else iREN → IACC, cnt←0.
  - else stay.
  - All RAM enables are 0; iwait=dwait=1.
- DACC:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN.
  - cnt increments each cycle.
  - Completion cycle (cnt==LAT-1): dwait=0, dload=ramload, next state IDLE.
- IACC:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - Completion cycle: iwait=0, iload=ramload, next state IDLE.
- Abort: if the granted requester drops all its request lines before completion, go to IDLE next cycle with no completion pulse. The requester owns any partial write.
- Priority: dcache always wins in IDLE. The icache may starve during a dcache flush; this is accepted.
- Inputs are sampled live, not latched. Requesters must hold address and data stable until their wait goes low.
- Default outputs when not driven: iload=dload=0, ramaddr=0, ramstore=0.

## Timing
- Reset (RST high at a clock edge):
  - state←IDLE, cnt←0.
  - Next cycle: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
- Reset mid-access discards the access; no wait pulse is issued.
- Latency: request visible in IDLE at cycle t; access occupies t+1..t+LAT; wait low in cycle t+LAT. Per word the cost is LAT+1 cycles.
- Back-to-back dcache words: after a completion the FSM returns to IDLE. The dcache's next request, visible in that IDLE cycle, wins over a pending iREN. A two-word block therefore takes 2·(LAT+1) cycles with no icache access between the words.
- dREN and dWEN high together: treated as a write.
- Never more than one of iwait/dwait low in any cycle.
- LAT=1: access is a single cycle and completion is immediate on cnt==0.

## Structure
- Shared package mem_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, IACC, DACC}.
  - localparam default LAT.
- Sub-module lat_counter: cnt register with clear/enable, exposing a done flag (cnt==LAT-1).
- The arbiter FSM and output mux stay in mem_arbiter.

## Test plan
- Reset: hold RST 2 cycles → iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0.
- Icache read, LAT=2, iREN=1, iaddr=0x40, ramload=0xDEADBEEF:
  - ramREN=1 and ramaddr=0x40 for 2 cycles.
  - iwait low in the 3rd cycle, with iload=0xDEADBEEF.
- Simultaneous iREN and dREN at cycle 0:
  - dcache served first; dwait low at cycle 2.
  - IDLE at cycle 3; icache access cycles 4–5; iwait low at cycle 5.
- Dcache write-back then fill (dWEN 0x100, 0x104, then dREN 0x200, 0x204) with iREN held high throughout:
  - Four dwait pulses, 3 cycles apart.
  - ramWEN for the first two words, ramREN for the last two.
  - No iwait pulse until all four complete.
- Abort: iREN dropped after 1 cycle of IACC (LAT=3) → IDLE next cycle, no iwait pulse, ramREN=0.
- RST asserted during DACC cycle 1 → no dwait pulse; next cycle in IDLE with all reset values.
